mfp_srec_ahb_write_buffer: RTL
==============================

# mfp_srec_ahb_write_buffer

Parametrised write-buffering AHB-Lite master between the SREC parser byte-write outputs (address, byte, enable) and the system AHB bus. It merges consecutive bytes of one word into a single word write and queues pending writes in a FIFO of configurable depth. It honours HREADY wait states and HRESP errors, and reports when it has drained so the system can return bus ownership to the CPU safely.

## Interface
- FIFO_DEPTH, 8: pending-entry FIFO depth; power of two, at least 2.
- MERGE, 1: 1 merges bytes of the same word into one entry; 0 makes every byte its own entry.
- HCLK  in  1  system clock; every register is rising-edge.
- HRESET  in  1  asynchronous, active-high reset.
- big_endian  in  1  byte-lane order; sampled on every byte accepted.
- load_active  in  1  loader in progress (parser in_progress); a falling edge forces a flush.
- write_address  in  32  byte address from the parser.
- write_byte  in  8  byte data.
- write_enable  in  1  one-cycle strobe that accepts one byte.
- busy  out  1  high while the holder is valid, the FIFO is non-empty, or the master FSM is not in IDLE.
- overflow  out  1  sticky; an entry was dropped because the FIFO was full.
- bus_error  out  1  sticky; a data phase completed with HRESP=1.
- HADDR  out  32  AHB address.
- HBURST  out  3  constant 3'b000 (SINGLE).
- HMASTLOCK  out  1  constant 0.
- HPROT  out  4  constant 4'b0011.
- HSIZE  out  3  3'b010 for a word write, 3'b000 for a byte write.
- HTRANS  out  2  2'b10 (NONSEQ) in the address phase, 2'b00 otherwise.
- HWDATA  out  32  write data, valid in the data phase.
- HWRITE  out  1  high in the address phase, 0 otherwise.
- HREADY  in  1  slave ready.
- HRESP  in  1  slave error.

## Operation
- **Byte lane:** lane = addr[1:0] when little-endian; lane = 3 − addr[1:0] when big-endian. The byte occupies bits [8·lane+7 : 8·lane] of the word.
- **Holder register:** {waddr[31:2], data[31:0], mask[3:0], valid}.
- **write_enable handling:**
  - If MERGE=1, valid=1, addr[31:2]=waddr, and the lane bit is clear: OR the byte into data and set the lane bit.
  - Otherwise: push the holder to the FIFO if valid, then load the new byte as a fresh holder with a single lane bit.
  - Push and reload happen in the same cycle; no byte is lost.
  - A rewrite of the same lane forces a flush first, so the earlier byte is preserved.
- **Flush triggers:**
  - mask becomes 4'hF: push on the next cycle, unless write_enable is high that cycle, in which case the push-plus-reload rule applies.
  - load_active falls: push the holder.
  - MERGE=0: push every cycle the holder is valid.
- **FIFO:** entries are {waddr, data, mask}, single-clock.
  - A push when full drops the entry and sets overflow.
  - A push and pop in the same cycle when full is legal and does not overflow.
- **Master FSM:** IDLE → ADDR → DATA → (ADDR | IDLE).
  - **IDLE:** if the FIFO is non-empty, pop the entry into a working register and go to ADDR.
  - **ADDR:**
    - Drive HTRANS=NONSEQ and HWRITE=1.
    - mask=F: HSIZE=word, HADDR={waddr,2'b00}.
    - Otherwise: HSIZE=byte, with HADDR low bits set to the lowest set lane, mapped back through the endian rule.
    - Hold all address signals until HREADY=1, then go to DATA.
  - **DATA:**
    - HTRANS=IDLE; drive HWDATA from the working data.
    - Stay while HREADY=0.
    - On HREADY=1: set bus_error if HRESP=1, then clear the lane just written (or the whole mask for a word write).
    - Next state: ADDR if lanes remain; else pop the next entry and go to ADDR if the FIFO is non-empty; else IDLE.
  - A bus error does not abort the remaining lanes or entries.
- **Reset (asynchronous, any time, including mid-transfer):**
  - Holder, FIFO, FSM, and sticky flags all clear.
  - HTRANS=00, HWRITE=0, HADDR=0, HWDATA=0, HSIZE=3'b010.
  - busy=0, overflow=0, bus_error=0.

## Timing
- write_enable in cycle N: holder updated at the N+1 edge.
- A push at edge E makes the FIFO non-empty at E.
- IDLE with the FIFO non-empty: HTRANS=NONSEQ on the following cycle.
- Zero-wait word write takes 2 cycles (ADDR, DATA). A partial entry with k lanes takes 2k cycles.
- Each HREADY=0 cycle stretches the current phase by one cycle. All outputs are held stable across wait states.
- busy falls the cycle after the last data phase completes with an empty FIFO and no valid holder.

## Test plan
- **Word merge:** MERGE=1, little-endian; bytes 11,22,33,44 to addresses 0x100–0x103 on consecutive cycles. Required: one NONSEQ, HSIZE=010, HADDR=0x100, HWDATA=0x44332211, then busy=0.
- **Big-endian partial flush:** same four bytes to 0x100–0x101 only, then load_active falls. Required: two byte writes, HADDR=0x100 with HWDATA[31:24]=0x11, and HADDR=0x101 with HWDATA[23:16]=0x22.
- **Wait states:** HREADY low for 3 cycles in the address phase and 2 in the data phase. Required: HADDR and HSIZE stable for 4 cycles and HWDATA stable for 3; the transfer completes exactly once.
- **Overflow:** FIFO_DEPTH=2, MERGE=0, HREADY held 0, 5 bytes written. Required: overflow=1, and after HREADY=1 exactly 3 transfers (1 in flight plus 2 queued).
- **Error response:** HRESP=1 on the second of three word writes. Required: bus_error=1 and the third write still issued.
- **Reset mid-data-phase:** HRESET pulsed. Required: HTRANS=00, busy=0, FIFO empty, and the next load starts cleanly.

Source files
------------

// File: rtl/mfp_srec_ahb_write_buffer_if.sv
// AHB-Lite bus bundle between the SREC write buffer (master) and the system
// slave side.
interface mfp_srec_ahb_write_buffer_if;
  logic [31:0] HADDR;
  logic [2:0]  HBURST;
  logic        HMASTLOCK;
  logic [3:0]  HPROT;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic        HWRITE;
  logic        HREADY;
  logic        HRESP;

  modport master (
    output HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWDATA, HWRITE,
    input  HREADY, HRESP
  );

  modport slave (
    input  HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWDATA, HWRITE,
    output HREADY, HRESP
  );
endinterface

// File: rtl/mfp_srec_ahb_write_buffer.sv
// Write-buffering AHB-Lite master: merges parser byte writes into word entries,
// queues them in a FIFO and replays them as single NONSEQ transfers.
module mfp_srec_ahb_write_buffer #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter bit          MERGE      = 1'b1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        big_endian,
  input  logic        load_active,
  input  logic [31:0] write_address,
  input  logic [7:0]  write_byte,
  input  logic        write_enable,
  output logic        busy,
  output logic        overflow,
  output logic        bus_error,
  mfp_srec_ahb_write_buffer_if.master ahb
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_e;

  // ---------------------------------------------------------------- holder
  logic [29:0] hold_addr_q, hold_addr_d;
  logic [31:0] hold_data_q, hold_data_d;
  logic [3:0]  hold_mask_q, hold_mask_d;
  logic        hold_big_q,  hold_big_d;
  logic        hold_valid_q, hold_valid_d;
  logic        load_active_q;

  logic [1:0]  in_lane;
  logic [3:0]  in_lane_oh;
  logic [31:0] in_word;
  logic        load_fall;
  logic        merge_hit;
  logic        push;

  assign in_lane    = big_endian ? ~write_address[1:0] : write_address[1:0];
  assign in_lane_oh = 4'b0001 << in_lane;
  assign in_word    = {24'h0, write_byte} << {in_lane, 3'b000};
  assign load_fall  = load_active_q & ~load_active;
  assign merge_hit  = MERGE && hold_valid_q && (write_address[31:2] == hold_addr_q)
                      && ((hold_mask_q & in_lane_oh) == 4'h0);

  // A new byte that cannot merge pushes the old holder and reloads in the same cycle.
  always_comb begin
    hold_addr_d  = hold_addr_q;
    hold_data_d  = hold_data_q;
    hold_mask_d  = hold_mask_q;
    hold_big_d   = hold_big_q;
    hold_valid_d = hold_valid_q;
    push         = 1'b0;
    if (write_enable) begin
      if (merge_hit) begin
        hold_data_d = hold_data_q | in_word;
        hold_mask_d = hold_mask_q | in_lane_oh;
      end else begin
        push         = hold_valid_q;
        hold_addr_d  = write_address[31:2];
        hold_data_d  = in_word;
        hold_mask_d  = in_lane_oh;
        hold_big_d   = big_endian;
        hold_valid_d = 1'b1;
      end
    end else if (hold_valid_q && (hold_mask_q == 4'hF || load_fall || !MERGE)) begin
      push         = 1'b1;
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      hold_addr_q   <= '0;
      hold_data_q   <= '0;
      hold_mask_q   <= '0;
      hold_big_q    <= 1'b0;
      hold_valid_q  <= 1'b0;
      load_active_q <= 1'b0;
    end else begin
      hold_addr_q   <= hold_addr_d;
      hold_data_q   <= hold_data_d;
      hold_mask_q   <= hold_mask_d;
      hold_big_q    <= hold_big_d;
      hold_valid_q  <= hold_valid_d;
      load_active_q <= load_active;
    end
  end

  // ------------------------------------------------------------------ FIFO
  logic [29:0] fifo_addr [FIFO_DEPTH];
  logic [31:0] fifo_data [FIFO_DEPTH];
  logic [3:0]  fifo_mask [FIFO_DEPTH];
  logic        fifo_big  [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        fifo_empty, fifo_full;
  logic        pop;
  logic        push_ok;
  logic [AW-1:0] rd_idx;

  assign rd_idx     = rd_ptr_q[AW-1:0];
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // A simultaneous pop frees the slot being written, so a full FIFO still accepts.
  assign push_ok    = push && (!fifo_full || pop);

  always_ff @(posedge HCLK) begin
    if (push_ok) begin
      fifo_addr[wr_ptr_q[AW-1:0]] <= hold_addr_q;
      fifo_data[wr_ptr_q[AW-1:0]] <= hold_data_q;
      fifo_mask[wr_ptr_q[AW-1:0]] <= hold_mask_q;
      fifo_big[wr_ptr_q[AW-1:0]]  <= hold_big_q;
    end
  end

  // ------------------------------------------------------------ master FSM
  state_e      state_q, state_d;
  logic [29:0] w_addr_q, w_addr_d;
  logic [31:0] w_data_q, w_data_d;
  logic [3:0]  w_mask_q, w_mask_d;
  logic        w_big_q,  w_big_d;
  logic        ovf_q, ovf_d;
  logic        err_q, err_d;
  logic [1:0]  low_lane;
  logic [3:0]  low_oh;
  logic [3:0]  mask_left;
  logic        word_xfer;

  always_comb begin
    if (w_mask_q[0])      low_lane = 2'd0;
    else if (w_mask_q[1]) low_lane = 2'd1;
    else if (w_mask_q[2]) low_lane = 2'd2;
    else                  low_lane = 2'd3;
  end

  assign low_oh    = 4'b0001 << low_lane;
  assign word_xfer = (w_mask_q == 4'hF);
  assign mask_left = word_xfer ? 4'h0 : (w_mask_q & ~low_oh);

  always_comb begin
    state_d  = state_q;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    w_mask_d = w_mask_q;
    w_big_d  = w_big_q;
    err_d    = err_q;
    pop      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          w_addr_d = fifo_addr[rd_idx];
          w_data_d = fifo_data[rd_idx];
          w_mask_d = fifo_mask[rd_idx];
          w_big_d  = fifo_big[rd_idx];
          state_d  = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (ahb.HREADY) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (ahb.HREADY) begin
          if (ahb.HRESP) err_d = 1'b1;
          w_mask_d = mask_left;
          if (mask_left != 4'h0) begin
            state_d = ST_ADDR;
          end else if (!fifo_empty) begin
            pop      = 1'b1;
            w_addr_d = fifo_addr[rd_idx];
            w_data_d = fifo_data[rd_idx];
            w_mask_d = fifo_mask[rd_idx];
            w_big_d  = fifo_big[rd_idx];
            state_d  = ST_ADDR;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ovf_d = ovf_q | (push & fifo_full & ~pop);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q  <= ST_IDLE;
      w_addr_q <= '0;
      w_data_q <= '0;
      w_mask_q <= '0;
      w_big_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
      w_mask_q <= w_mask_d;
      w_big_q  <= w_big_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------- outputs
  assign ahb.HBURST    = 3'b000;
  assign ahb.HMASTLOCK = 1'b0;
  assign ahb.HPROT     = 4'b0011;
  assign ahb.HTRANS    = (state_q == ST_ADDR) ? 2'b10 : 2'b00;
  assign ahb.HWRITE    = (state_q == ST_ADDR);
  assign ahb.HSIZE     = (state_q != ST_IDLE && !word_xfer) ? 3'b000 : 3'b010;
  assign ahb.HADDR     = (state_q == ST_IDLE) ? '0 :
                         {w_addr_q, word_xfer ? 2'b00 : (w_big_q ? ~low_lane : low_lane)};
  assign ahb.HWDATA    = (state_q == ST_DATA) ? w_data_q : '0;

  assign busy      = hold_valid_q | ~fifo_empty | (state_q != ST_IDLE);
  assign overflow  = ovf_q;
  assign bus_error = err_q;

endmodule
